// File: rtl/code_encoder_pkg.sv
// Shared code table for the lab-1 3-bit <-> 4-bit code link, used by both
// the decoder (index -> code) and this encoder (code -> index).
package code_encoder_pkg;

    localparam logic [3:0] CODE_0 = 4'b0100;
    localparam logic [3:0] CODE_1 = 4'b1010;
    localparam logic [3:0] CODE_2 = 4'b0111;
    localparam logic [3:0] CODE_3 = 4'b1100;
    localparam logic [3:0] CODE_4 = 4'b1001;
    localparam logic [3:0] CODE_5 = 4'b1101;
    localparam logic [3:0] CODE_6 = 4'b0000;
    localparam logic [3:0] CODE_7 = 4'b0010;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } lookup_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    function automatic lookup_t code_lookup(input logic [3:0] code);
        lookup_t r;
        r = '{valid: 1'b1, idx: 3'd0};
        case (code)
            CODE_0:  r.idx = 3'd0;
            CODE_1:  r.idx = 3'd1;
            CODE_2:  r.idx = 3'd2;
            CODE_3:  r.idx = 3'd3;
            CODE_4:  r.idx = 3'd4;
            CODE_5:  r.idx = 3'd5;
            CODE_6:  r.idx = 3'd6;
            CODE_7:  r.idx = 3'd7;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/code_fifo2.sv
// Generic 2-entry valid/ready buffer. Head always lives in r_mem[0];
// ready depends on occupancy only, never on the downstream ready.
module code_fifo2
    import code_encoder_pkg::*;
#(
    parameter int unsigned DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data
);

    logic [DW-1:0] r_mem [2];
    occ_t          r_occ;
    logic          w_push;
    logic          w_pop;

    assign o_ready = (r_occ != OCC_TWO);
    assign o_valid = (r_occ != OCC_EMPTY);
    assign o_data  = o_valid ? r_mem[0] : '0;
    assign w_push  = i_valid & o_ready;
    assign w_pop   = o_valid & i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ    <= OCC_EMPTY;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == OCC_EMPTY) begin
                        r_mem[0] <= i_data;
                        r_occ    <= OCC_ONE;
                    end else begin
                        r_mem[1] <= i_data;
                        r_occ    <= OCC_TWO;
                    end
                end
                2'b01: begin
                    r_mem[0] <= r_mem[1];
                    r_occ    <= (r_occ == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
                end
                // push+pop only happens at one entry: new word replaces the head
                2'b11:   r_mem[0] <= i_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/code_encoder.sv
// Streaming 4-bit codeword -> 3-bit index encoder with invalid-word
// flagging/dropping, saturating error statistics and a 2-entry output buffer.
module code_encoder
    import code_encoder_pkg::*;
#(
    parameter int unsigned ERR_CNT_W    = 8,
    parameter int unsigned DROP_INVALID = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           out_y,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 err_sticky,
    input  logic                 clr
);

    lookup_t               w_lk;
    logic                  w_accept;
    logic                  w_bad;
    logic                  w_enq;
    logic [3:0]            w_din;
    logic [3:0]            w_dout;
    logic [ERR_CNT_W-1:0]  r_err_cnt;
    logic                  r_err_sticky;

    assign w_lk     = code_lookup(in_code);
    assign w_accept = in_valid & in_ready;
    assign w_bad    = w_accept & ~w_lk.valid;
    // dropped words still see in_ready; they simply never reach the buffer
    assign w_enq    = in_valid & (w_lk.valid | (DROP_INVALID == 0));
    assign w_din    = w_lk.valid ? {w_lk.idx, 1'b0} : 4'b0001;

    code_fifo2 #(.DW(4)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_enq),
        .o_ready (in_ready),
        .i_data  (w_din),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_dout)
    );

    assign out_y   = w_dout[3:1];
    assign out_err = w_dout[0];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_err_cnt    <= '0;
            r_err_sticky <= 1'b0;
        end else if (w_bad) begin
            r_err_sticky <= 1'b1;
            if (r_err_cnt != '1)
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt    = r_err_cnt;
    assign err_sticky = r_err_sticky;

endmodule
